tcm_axis_packet_source: RTL

AXI-Stream master that generates test packets for the TCM AXI test IP and feeds its 8-word stream sink directly. A start request on the user control word produces one packet of 1–8 words, with TLAST on the final word. The payload is either an incrementing count or an LFSR sequence, both derived from a seed in the control word. Software triggers packets through USR_tcm_control, and a status port reports progress.

---
 rtl/tcm_axi_pkg.sv | 37 +++
 rtl/tcm_payload_gen.sv | 50 +++++
 rtl/tcm_axis_packet_source.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tcm_axi_pkg.sv
// Shared definitions for the TCM AXI test IP: FSM states, control/status
// field positions, LFSR polynomial and a width helper.
package tcm_axi_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_MODE_BIT  = 1;
  localparam int unsigned CTRL_LEN_LSB   = 4;
  localparam int unsigned CTRL_LEN_W     = 3;
  localparam int unsigned CTRL_SEED_LSB  = 16;
  localparam int unsigned SEED_W         = 16;

  localparam int unsigned STAT_BUSY_BIT      = 0;
  localparam int unsigned STAT_INIT_DONE_BIT = 1;
  localparam int unsigned STAT_WORDS_LSB     = 8;
  localparam int unsigned STAT_WORDS_W       = 8;
  localparam int unsigned STAT_PKTS_LSB      = 16;

  localparam int unsigned WORD_CNT_W = 4;
  localparam int unsigned PKT_CNT_W  = 16;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Bits needed to count 0..value-1 (at least one bit).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tcm_payload_gen.sv
// Payload word register: loads the seed word at packet start and steps to
// the next increment/LFSR value on each accepted transfer.
module tcm_payload_gen
  import tcm_axi_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [SEED_W-1:0] seed,
  input  logic              advance,
  input  logic              clear,
  output logic [DATA_W-1:0] data
);

  logic              mode_q;
  logic [DATA_W-1:0] seed_word_c;
  logic [DATA_W-1:0] next_word_c;

  // LFSR never starts from the all-zero lock-up state.
  always_comb begin
    seed_word_c = DATA_W'(seed);
    if (mode && (seed == '0)) seed_word_c = DATA_W'(1);
  end

  always_comb begin
    next_word_c = data + DATA_W'(1);
    if (mode_q) begin
      next_word_c = data >> 1;
      if (data[0]) next_word_c = (data >> 1) ^ DATA_W'(LFSR_MASK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      data   <= '0;
    end else if (load) begin
      mode_q <= mode;
      data   <= seed_word_c;
    end else if (clear) begin
      data   <= '0;
    end else if (advance) begin
      data   <= next_word_c;
    end
  end

endmodule

// File: rtl/tcm_axis_packet_source.sv
// AXI-Stream packet source: waits out a post-reset delay, then emits one
// 1..N word packet per rising edge of the control start bit.
module tcm_axis_packet_source
  import tcm_axi_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int unsigned C_M_START_COUNT        = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_WORDS = 8
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic [31:0]                       USR_tcm_control,
  output logic [31:0]                       USR_tcm_status,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned INIT_CNT_W = clogb2(C_M_START_COUNT);
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(C_M_START_COUNT - 1);
  localparam logic [WORD_CNT_W-1:0] MAX_LEN   = WORD_CNT_W'(NUMBER_OF_OUTPUT_WORDS);

  state_t                  state_q, state_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                    start_q, start_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WORD_CNT_W-1:0]   len_q, len_d;
  logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                    busy_q, busy_d;
  logic                    init_done_q, init_done_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;

  logic                    start_edge_c;
  logic                    xfer_c;
  logic                    load_c;
  logic                    advance_c;
  logic                    clear_c;
  logic [WORD_CNT_W-1:0]   len_raw_c;
  logic [WORD_CNT_W-1:0]   len_c;
  logic                    unused_ctrl_c;

  assign unused_ctrl_c = ^{USR_tcm_control[15:7], USR_tcm_control[3:2]};

  assign start_edge_c = USR_tcm_control[CTRL_START_BIT] && !start_q;
  assign xfer_c       = tvalid_q && M_AXIS_TREADY;
  assign len_raw_c    = WORD_CNT_W'(USR_tcm_control[CTRL_LEN_LSB +: CTRL_LEN_W]) + WORD_CNT_W'(1);
  assign len_c        = (len_raw_c > MAX_LEN) ? MAX_LEN : len_raw_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    start_d     = USR_tcm_control[CTRL_START_BIT];
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    pkt_cnt_d   = pkt_cnt_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    load_c      = 1'b0;
    advance_c   = 1'b0;
    clear_c     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (start_edge_c) begin
          state_d    = ST_SEND;
          load_c     = 1'b1;
          len_d      = len_c;
          word_cnt_d = '0;
          busy_d     = 1'b1;
          tvalid_d   = 1'b1;
          tlast_d    = (len_c == WORD_CNT_W'(1));
        end
      end
      ST_SEND: begin
        if (xfer_c) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          if (tlast_q) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            clear_c   = 1'b1;
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
          end else begin
            advance_c = 1'b1;
            // The word after this one is last when its index equals len-1.
            tlast_d   = ((word_cnt_q + WORD_CNT_W'(2)) == len_q);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      start_q     <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      pkt_cnt_q   <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      start_q     <= start_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  tcm_payload_gen #(
    .DATA_W (C_M_AXIS_TDATA_WIDTH)
  ) u_payload_gen (
    .clk     (M_AXIS_ACLK),
    .rst     (M_AXIS_ARESET),
    .load    (load_c),
    .mode    (USR_tcm_control[CTRL_MODE_BIT]),
    .seed    (USR_tcm_control[CTRL_SEED_LSB +: SEED_W]),
    .advance (advance_c),
    .clear   (clear_c),
    .data    (M_AXIS_TDATA)
  );

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){tvalid_q}};

  // Status word is a straight map of registered state.
  always_comb begin
    USR_tcm_status                                     = '0;
    USR_tcm_status[STAT_BUSY_BIT]                      = busy_q;
    USR_tcm_status[STAT_INIT_DONE_BIT]                 = init_done_q;
    USR_tcm_status[STAT_WORDS_LSB +: STAT_WORDS_W]     = STAT_WORDS_W'(word_cnt_q);
    USR_tcm_status[STAT_PKTS_LSB +: PKT_CNT_W]         = pkt_cnt_q;
  end

endmodule
